dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//   Parametrised data memory with a RISC-V load/store front end: byte/half/word
//   access, sign/zero extension, valid/ready request port, fixed-latency in-order
//   response pipeline and address-fault reporting. Sits between the datapath
//   (funct3, ALU address, rs2 data) and the on-chip data RAM, generalising the
//   single-cycle word-only data memory.
// PARAMETERS
//   DEPTH_WORDS  128  number of 32-bit words; power of two, >= 4
//   RD_LAT       1    request-to-response latency in cycles; legal 1..4
//   ADDR_W       32   byte-address width of addr
// PORTS
//   clk         in   1       clock; all state updates on rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   req_valid   in   1       request present this cycle
//   req_ready   out  1       block can accept; request accepted when valid & ready
//   req_we      in   1       1 = store, 0 = load
//   req_funct3  in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//   addr        in   ADDR_W  byte address
//   wdata       in   32      store data; low byte/half used for SB/SH
//   resp_valid  out  1       one-cycle pulse, one per accepted request, in order
//   resp_rdata  out  32      extended load data; 0 for stores and faults
//   resp_err    out  1       access faulted (range or misalign); valid with resp_valid
// BEHAVIOUR
//   - Reset: req_ready=0 while rst_n low, 1 from first edge after release;
//     resp_valid=0, resp_rdata=0, resp_err=0; pipeline valid bits cleared.
//     RAM contents are not reset. Reset mid-operation drops in-flight responses;
//     stores already committed stay committed.
//   - req_ready=1 every cycle out of reset (fully pipelined, one request/cycle).
//   - Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
//   - Range fault: any addr bit above log2(DEPTH_WORDS)+1 set, or illegal funct3
//     (011, 110, 111; 100/101 with req_we=1) -> resp_err=1, no RAM write.
//   - Store: committed at acceptance edge using byte enables (SB 1 lane, SH 2
//     lanes, SW 4); untouched bytes preserved. Store response after RD_LAT cycles.
//   - Load: RAM read at acceptance; lane select + sign (B/H) or zero (BU/HU)
//     extension; resp_valid/resp_rdata exactly RD_LAT cycles after acceptance.
//   - Ordering: store accepted cycle N is visible to a load accepted cycle N+1.
//   - Pipeline: RD_LAT-stage shift of {valid, err, rdata}; back-to-back requests
//     give back-to-back responses, no bubbles, no reordering.
// CONFIGURATION
//   DMEM_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0
//     -> resp_err=1, resp_rdata=0, no RAM write.
//   Not defined: misaligned low address bits forced to natural alignment
//     (H: addr[0]=0, W: addr[1:0]=0); access proceeds; err only for range/funct3.
// STRUCTURE
//   - dmem_pkg: funct3 localparams (F3_B/H/W/BU/HU), byte-enable and
//     extension-type typedefs, RD_LAT legal-range constants.
//   - Sub-module dmem_load_align: combinational lane select + sign/zero extend
//     (word, addr[1:0], funct3 -> 32-bit result); instantiated before stage 1.
//   - Top: decode/fault check, byte-enable write, RAM array, latency pipeline.
// TESTING
//   1 Reset: hold rst_n=0 with req_valid=1, req_we=1 -> no write, resp_valid=0,
//     req_ready=0; release -> req_ready=1 next edge.
//   2 SW 0x8000_00FF @0x10, then LB/LBU/LH/LHU/LW @0x10 -> 0xFFFF_FFFF,
//     0x0000_00FF, 0x0000_00FF, 0x0000_00FF, 0x8000_00FF; LH @0x12 -> 0xFFFF_8000.
//   3 SW 0x1122_3344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22, LW @0x20 (back-to-back)
//     -> 0xBEEF_AA44 returned RD_LAT cycles after LW accept, resp_err=0.
//   4 Misaligned LW @0x22: with DMEM_MISALIGN_TRAP_EN -> resp_err=1, rdata=0;
//     without -> data of word @0x20, resp_err=0. SW @0x23 trapped -> @0x20 unchanged.
//   5 Out-of-range LW @ DEPTH_WORDS*4 and funct3=011 -> resp_err=1, RAM unchanged.
//   6 RD_LAT=3, 8 back-to-back loads then reset asserted mid-stream -> first
//     responses in order, one per cycle; after reset no stale resp_valid.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared load/store decode constants and helpers for the data-memory LSU.
// Consumed by dmem_lsu and dmem_load_align.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef logic [3:0] byte_en_t;

  typedef enum logic [1:0] {
    EXT_NONE,
    EXT_SIGN,
    EXT_ZERO
  } ext_e;

  // Lane is expected to be already aligned to the access size.
  function automatic byte_en_t byteEnable(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_B:    return byte_en_t'(4'b0001 << lane);
      F3_H:    return byte_en_t'(4'b0011 << lane);
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic ext_e extType(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H:   return EXT_SIGN;
      F3_BU, F3_HU: return EXT_ZERO;
      default:      return EXT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load lane select with sign/zero extension.
// Word and halfword lanes must arrive already aligned.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;
  logic        w_signed;

  always_comb begin
    w_shifted = i_word >> {i_lane, 3'b000};
    w_signed  = (extType(i_funct3) == EXT_SIGN);
    o_data    = '0;
    case (i_funct3)
      F3_B, F3_BU: o_data = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      F3_H, F3_HU: o_data = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      F3_W:        o_data = i_word;
      default:     o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with RISC-V byte/half/word load/store front end and a fixed
// RD_LAT response pipeline. Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/W.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int RD_LAT      = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic              r_ready;
  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [RD_LAT-1:0] r_pipeValid;
  logic [RD_LAT-1:0] r_pipeErr;
  logic [31:0]       r_pipeData [RD_LAT];

  logic             w_accept;
  logic             w_funct3Bad;
  logic             w_rangeBad;
  logic             w_err;
  logic [1:0]       w_lane;
  logic [IDX_W-1:0] w_idx;
  byte_en_t         w_be;
  logic [31:0]      w_wdataRep;
  logic [31:0]      w_word;
  logic [31:0]      w_loadData;
  logic [31:0]      w_respData;

  assign w_accept = req_valid & r_ready;
  assign w_idx    = addr[IDX_W+1:2];

  always_comb begin
    w_funct3Bad = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: w_funct3Bad = 1'b0;
      F3_BU, F3_HU:     w_funct3Bad = req_we;
      default:          w_funct3Bad = 1'b1;
    endcase
    w_rangeBad = (addr >> (IDX_W + 2)) != '0;
  end

  // The lane is always naturally aligned; trapping builds flag the dropped bits instead.
  always_comb begin
    w_lane     = addr[1:0];
    w_wdataRep = wdata;
    case (req_funct3)
      F3_B: w_wdataRep = {4{wdata[7:0]}};
      F3_H: begin
        w_lane     = {addr[1], 1'b0};
        w_wdataRep = {2{wdata[15:0]}};
      end
      F3_HU:   w_lane = {addr[1], 1'b0};
      F3_W:    w_lane = 2'b00;
      default: w_lane = addr[1:0];
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_misaligned;

  always_comb begin
    w_misaligned = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: w_misaligned = addr[0];
      F3_W:        w_misaligned = |addr[1:0];
      default:     w_misaligned = 1'b0;
    endcase
  end

  assign w_err = w_funct3Bad | w_rangeBad | w_misaligned;
`else
  assign w_err = w_funct3Bad | w_rangeBad;
`endif

  assign w_be   = byteEnable(req_funct3, w_lane);
  assign w_word = r_mem[w_idx];

  dmem_load_align u_align (
    .i_word   (w_word),
    .i_lane   (w_lane),
    .i_funct3 (req_funct3),
    .o_data   (w_loadData)
  );

  assign w_respData = (req_we | w_err) ? 32'h0 : w_loadData;

  // RAM is deliberately left out of reset; committed stores survive a reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdataRep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready <= 1'b0;
    else        r_ready <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipeValid <= '0;
      r_pipeErr   <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipeData[i] <= '0;
    end else begin
      r_pipeValid[0] <= w_accept;
      r_pipeErr[0]   <= w_accept & w_err;
      r_pipeData[0]  <= w_accept ? w_respData : 32'h0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeErr[i]   <= r_pipeErr[i-1];
        r_pipeData[i]  <= r_pipeData[i-1];
      end
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_pipeValid[RD_LAT-1];
  assign resp_err   = r_pipeErr[RD_LAT-1];
  assign resp_rdata = r_pipeData[RD_LAT-1];

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a byte-level reference memory predicts every
// response, which is queued at drive time and matched when resp_valid fires.
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int DEPTH  = 128;
  localparam int RD_LAT = 3;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
    logic [31:0] id;
  } sbEntry_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int       testsRun = 0;
  int       testsFailed = 0;
  int       seenCount = 0;
  int       nextId = 0;
  int       cycleCount = 0;
  sbEntry_t sb[$];
  logic [7:0] modelMem [DEPTH*4];

  dmem_lsu #(
    .DEPTH_WORDS (DEPTH),
    .RD_LAT      (RD_LAT),
    .ADDR_W      (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference behaviour worked out byte by byte from the access size.
  task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int          n;
    bit          sgn;
    bit          legal;
    logic [31:0] ea;
    logic [31:0] v;
    n = 1; sgn = 0; legal = 1;
    case (f3)
      F3_B:  begin n = 1; sgn = 1; end
      F3_H:  begin n = 2; sgn = 1; end
      F3_W:  begin n = 4; sgn = 0; end
      F3_BU: begin n = 1; legal = !we; end
      F3_HU: begin n = 2; legal = !we; end
      default: legal = 0;
    endcase
    err = !legal || (a >= 32'(DEPTH*4));
    ea  = a;
    if (legal && (a % 32'(n)) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      err = 1'b1;
`else
      ea = a - (a % 32'(n));
`endif
    end
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) modelMem[ea + 32'(i)] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(modelMem[ea + 32'(i)]) << (8*i));
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
    sbEntry_t    e;
    logic        err;
    logic [31:0] rd;
    @(posedge clk); #1;
    checkOutput($sformatf("ready_at_req%0d", nextId), {31'b0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    addr       = a;
    wdata      = wd;
    modelAccess(we, f3, a, wd, err, rd);
    e.err   = err;
    e.rdata = rd;
    e.cyc   = 32'(cycleCount + RD_LAT);
    e.id    = 32'(nextId);
    nextId++;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checkOutput(tag, 32'(sb.size()), 32'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, {31'b0, req_ready}, 32'h0);
    checkOutput({tag, "_valid"}, {31'b0, resp_valid}, 32'h0);
    checkOutput({tag, "_rdata"}, resp_rdata, 32'h0);
    checkOutput({tag, "_err"}, {31'b0, resp_err}, 32'h0);
  endtask

  // Every response must match the oldest outstanding expectation, on the predicted cycle.
  always @(negedge clk) begin
    sbEntry_t e;
    if (resp_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", {31'b0, resp_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        seenCount++;
        checkOutput($sformatf("rdata#%0d", e.id), resp_rdata, e.rdata);
        checkOutput($sformatf("err#%0d", e.id), {31'b0, resp_err}, {31'b0, e.err});
        checkOutput($sformatf("cycle#%0d", e.id), 32'(cycleCount), e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [2:0]  t6F3   [8];
  logic [31:0] t6Addr [8];
  int          seenBase;
  int          resetCycle;

  initial begin
    t6F3   = '{F3_W, F3_BU, F3_H, F3_W, F3_B, F3_HU, F3_W, F3_BU};
    t6Addr = '{32'h10, 32'h21, 32'h22, 32'h1FC, 32'h13, 32'h30, 32'h30, 32'h33};

    // Reset held with a store pending: nothing may be accepted or written.
    rst_n      = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    addr       = 32'h30;
    wdata      = 32'h0BAD_F00D;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("rst1");
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", {31'b0, req_ready}, 32'h0);
    @(posedge clk); #1;
    checkOutput("ready_after_edge", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b0;

    // Sign/zero extension on a word with set MSBs in both bytes and halves.
    applyStimulus(1'b1, F3_W,  32'h10, 32'h8000_00FF);
    applyStimulus(1'b0, F3_B,  32'h10, 32'h0);
    applyStimulus(1'b0, F3_BU, 32'h10, 32'h0);
    applyStimulus(1'b0, F3_H,  32'h10, 32'h0);
    applyStimulus(1'b0, F3_HU, 32'h10, 32'h0);
    applyStimulus(1'b0, F3_W,  32'h10, 32'h0);
    applyStimulus(1'b0, F3_H,  32'h12, 32'h0);

    // Back-to-back partial stores merged then read in the very next cycle.
    applyStimulus(1'b1, F3_W,  32'h20, 32'h1122_3344);
    applyStimulus(1'b1, F3_B,  32'h21, 32'h0000_00AA);
    applyStimulus(1'b1, F3_H,  32'h22, 32'h0000_BEEF);
    applyStimulus(1'b0, F3_W,  32'h20, 32'h0);
    applyStimulus(1'b1, F3_W,  32'h30, 32'hCAFE_F00D);
    applyStimulus(1'b1, F3_W,  32'h1FC, 32'h5A5A_A5A5);
    applyStimulus(1'b0, F3_W,  32'h1FC, 32'h0);

    // Misaligned accesses.
    applyStimulus(1'b0, F3_W,  32'h22, 32'h0);
    applyStimulus(1'b0, F3_H,  32'h21, 32'h0);
    applyStimulus(1'b1, F3_W,  32'h23, 32'h7777_7777);
    applyStimulus(1'b0, F3_W,  32'h20, 32'h0);

    // Range and funct3 faults must leave memory untouched.
    applyStimulus(1'b1, F3_W,  32'(DEPTH*4) + 32'h10, 32'hDEAD_DEAD);
    applyStimulus(1'b0, F3_W,  32'(DEPTH*4), 32'h0);
    applyStimulus(1'b0, F3_W,  32'h8000_0010, 32'h0);
    applyStimulus(1'b1, 3'b011, 32'h10, 32'h1234_5678);
    applyStimulus(1'b1, F3_BU, 32'h10, 32'h0000_0011);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0);
    applyStimulus(1'b0, 3'b110, 32'h10, 32'h0);
    applyStimulus(1'b0, F3_W,  32'h10, 32'h0);
    idle();
    drain("drain_main");

    // Streaming loads interrupted by reset; later responses must vanish.
    seenBase = seenCount;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, t6F3[i], t6Addr[i], 32'h0);
    @(posedge clk); #1;
    resetCycle = cycleCount;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    addr       = 32'h30;
    wdata      = 32'h1234_5678;
    while (sb.size() > 0 && sb[$].cyc >= 32'(resetCycle)) void'(sb.pop_back());
    checkOutput("stream_pending", 32'(sb.size()), 32'h0);
    checkOutput("stream_seen", 32'(seenCount - seenBase), 32'(8 - RD_LAT));
    repeat (3) @(negedge clk);
    checkResetOutputs("rst2");
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("ready_after_rst2", {31'b0, req_ready}, 32'h1);
    applyStimulus(1'b0, F3_W, 32'h30, 32'h0);
    applyStimulus(1'b0, F3_W, 32'h10, 32'h0);
    idle();
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
